wb_write_queue: RTL

//   Write-side front end for the 32x32 register file. Accepts register writes from two

---
 rtl/wb_write_queue_if.sv | 24 ++
 rtl/wb_write_queue.sv | 101 ++++++++++
 2 files changed

// File: rtl/wb_write_queue_if.sv
// Producer-side write request bundle for the register-file write queue.
// Producer A is the WB stage, producer B the mult/div unit.
interface wb_write_queue_if;
    logic        a_valid;
    logic        a_ready;
    logic [4:0]  a_wn;
    logic [31:0] a_wd;
    logic        b_valid;
    logic        b_ready;
    logic [4:0]  b_wn;
    logic [31:0] b_wd;

    modport master (
        output a_valid, a_wn, a_wd,
        output b_valid, b_wn, b_wd,
        input  a_ready, b_ready
    );

    modport slave (
        input  a_valid, a_wn, a_wd,
        input  b_valid, b_wn, b_wd,
        output a_ready, b_ready
    );
endinterface

// File: rtl/wb_write_queue.sv
// In-order write queue in front of the 32x32 register file's single write port,
// with youngest-match bypass for the two ID-stage read ports.
module wb_write_queue #(
    parameter int DEPTH = 4,
    parameter int AW    = 2
) (
    input  logic              clk,
    input  logic              rst,
    wb_write_queue_if.slave   wq,
    output logic              RegWrite,
    output logic [4:0]        WN,
    output logic [31:0]       WD,
    input  logic [4:0]        RN1,
    input  logic [4:0]        RN2,
    output logic              fwd1_hit,
    output logic [31:0]       fwd1_data,
    output logic              fwd2_hit,
    output logic [31:0]       fwd2_data,
    output logic [AW:0]       count
);

    localparam int CW = AW + 1;

    logic [AW-1:0] head;
    logic [AW-1:0] tail;
    logic [AW-1:0] b_slot;
    logic [4:0]    mem_wn [DEPTH];
    logic [31:0]   mem_wd [DEPTH];

    logic enq_a;
    logic enq_b;
    logic pop;

    // Ready is a function of registered occupancy only, so valid never loops back.
    assign wq.a_ready = count < CW'(DEPTH);
    assign wq.b_ready = count < CW'(DEPTH - 1);

    // Writes to r0 complete the handshake but never take a slot.
    assign enq_a  = wq.a_valid && wq.a_ready && (wq.a_wn != 5'd0);
    assign enq_b  = wq.b_valid && wq.b_ready && (wq.b_wn != 5'd0);
    assign b_slot = enq_a ? tail + AW'(1) : tail;
    assign pop    = count != '0;

    always_ff @(posedge clk) begin
        if (rst) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            head  <= head + AW'(pop);
            tail  <= tail + AW'(enq_a) + AW'(enq_b);
            count <= count + CW'(enq_a) + CW'(enq_b) - CW'(pop);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && enq_a) begin
            mem_wn[tail] <= wq.a_wn;
            mem_wd[tail] <= wq.a_wd;
        end
        if (!rst && enq_b) begin
            mem_wn[b_slot] <= wq.b_wn;
            mem_wd[b_slot] <= wq.b_wd;
        end
    end

    // The register file always accepts, so the head drains every non-empty cycle.
    always_comb begin
        RegWrite = pop && !rst;
        WN       = '0;
        WD       = '0;
        if (RegWrite) begin
            WN = mem_wn[head];
            WD = mem_wd[head];
        end
    end

    // Walk oldest to youngest so the last match left standing is the youngest.
    always_comb begin
        logic [AW-1:0] idx;
        idx       = '0;
        fwd1_hit  = 1'b0;
        fwd1_data = '0;
        fwd2_hit  = 1'b0;
        fwd2_data = '0;
        for (int i = 0; i < DEPTH; i++) begin
            idx = head + AW'(i);
            if (CW'(i) < count) begin
                if (RN1 != 5'd0 && mem_wn[idx] == RN1) begin
                    fwd1_hit  = 1'b1;
                    fwd1_data = mem_wd[idx];
                end
                if (RN2 != 5'd0 && mem_wn[idx] == RN2) begin
                    fwd2_hit  = 1'b1;
                    fwd2_data = mem_wd[idx];
                end
            end
        end
    end

endmodule
